button_conditioner: RTL and testbench



---
 rtl/reaction_pkg.sv | 11 +
 rtl/debounce_channel.sv | 50 +++++
 rtl/button_conditioner.sv | 34 +++
 tb/tb_button_conditioner.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared constants for the reaction-timer input stage
package reaction_pkg;

  localparam int BTN_START = 0;
  localparam int BTN_REACT = 1;

  localparam int NUM_BTNS_DEFAULT        = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 10000;
  localparam int CNT_W_DEFAULT           = 16;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, stability counter, level and edge pulses
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      stable        <= 1'b0;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= raw;
      sync2         <= sync1;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // change has held for the full window: accept it and emit one edge pulse
        stable        <= sync2;
        cnt           <= '0;
        press         <= sync2;
        release_pulse <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced levels and press/release pulses for all buttons
module button_conditioner
  import reaction_pkg::*;
#(
  parameter int NUM_BTNS        = NUM_BTNS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic                any_press
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw          (btn_raw[i]),
      .level        (btn_level[i]),
      .press        (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner with a 4-cycle window
module tb_button_conditioner;

  localparam int D   = 4;
  localparam int LAT = D + 2;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic       any_press;

  int  cyc = 0;
  int  n_total = 0;
  int  n_bad = 0;
  ev_t exp_q[$];

  button_conditioner #(
    .NUM_BTNS       (2),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // stimulus driven now is sampled at the next edge (edge 0); pulse visible after edge D+1
  task automatic expect_ev(input logic [1:0] p, input logic [1:0] r);
    ev_t e;
    e.cyc   = cyc + LAT;
    e.press = p;
    e.rel   = r;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if ((btn_press | btn_release) != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {btn_press, btn_release}, 4'h0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("pulse_cyc", cyc, e.cyc);
          check("pulse_press", btn_press, e.press);
          check("pulse_release", btn_release, e.rel);
          check("pulse_any", any_press, |e.press);
        end
      end else begin
        check("idle_any", any_press, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with both buttons held
    btn_raw = 2'b11;
    step(3);
    check("rst_level", btn_level, 2'b00);
    check("rst_press", btn_press, 2'b00);
    check("rst_release", btn_release, 2'b00);
    check("rst_any", any_press, 1'b0);
    rst_n = 1'b1;
    expect_ev(2'b11, 2'b00);
    step(LAT - 1);
    check("rst_level_pre", btn_level, 2'b00);
    step(1);
    check("rst_level_post", btn_level, 2'b11);
    step(4);
    btn_raw = 2'b00;
    expect_ev(2'b00, 2'b11);
    step(LAT + 4);
    check("rst_level_final", btn_level, 2'b00);

    // clean press and release on start
    btn_raw[0] = 1'b1;
    expect_ev(2'b01, 2'b00);
    step(LAT - 1);
    check("clean_level_pre", btn_level, 2'b00);
    step(1);
    check("clean_level_post", btn_level, 2'b01);
    step(20 - LAT);
    btn_raw[0] = 1'b0;
    expect_ev(2'b00, 2'b01);
    step(LAT - 1);
    check("clean_rel_level_pre", btn_level, 2'b01);
    step(1);
    check("clean_rel_level_post", btn_level, 2'b00);
    step(4);

    // glitch on react, shorter than the window
    btn_raw[1] = 1'b1;
    step(3);
    btn_raw[1] = 1'b0;
    step(8);
    check("glitch_level", btn_level, 2'b00);
    check("glitch_cnt", dut.g_ch[1].u_ch.cnt, 16'd0);

    // bounce on start, then hold high
    for (int i = 0; i < 6; i++) begin
      btn_raw[0] = ~btn_raw[0];
      step(2);
    end
    btn_raw[0] = 1'b1;
    expect_ev(2'b01, 2'b00);
    step(LAT + 2);
    check("bounce_level", btn_level, 2'b01);
    btn_raw[0] = 1'b0;
    expect_ev(2'b00, 2'b01);
    step(LAT + 2);

    // simultaneous press and release
    btn_raw = 2'b11;
    expect_ev(2'b11, 2'b00);
    step(LAT + 3);
    check("simul_level", btn_level, 2'b11);
    btn_raw = 2'b00;
    expect_ev(2'b00, 2'b11);
    step(LAT + 3);

    // reset in the middle of a count
    btn_raw[0] = 1'b1;
    step(4);
    check("mid_cnt", dut.g_ch[0].u_ch.cnt, 16'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cnt", dut.g_ch[0].u_ch.cnt, 16'd0);
    check("mid_rst_level", btn_level, 2'b00);
    check("mid_rst_press", btn_press, 2'b00);
    step(3);
    rst_n = 1'b1;
    expect_ev(2'b01, 2'b00);
    step(LAT + 3);
    check("mid_level", btn_level, 2'b01);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
